// File: rtl/pipe_hs_reg.sv
// Handshake pipeline stage register carrying a DW-bit payload with hold/flush flow control.
// Define PIPE_HS_SKID_EN for a 2-entry skid build whose in_ready_o is a pure register output.
module pipe_hs_reg #(
    parameter int unsigned   DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i,
    input  logic          fc_bk_i,
    input  logic          fc_flush_i,
    output logic [1:0]    occ_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic          in_fire;
    logic          out_fire;

    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i & in_ready_o & ~fc_bk_i & ~fc_flush_i;
    assign out_fire    = out_valid_o & out_ready_i & ~fc_bk_i;

`ifdef PIPE_HS_SKID_EN
    logic [DW-1:0] skid_q, skid_d;

    assign in_ready_o = (state_q != TWO);
    assign occ_o      = {state_q == TWO, state_q == ONE};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (!fc_bk_i) begin
            if (fc_flush_i) begin
                state_d = EMPTY;
                main_d  = RST_VAL;
                skid_d  = RST_VAL;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_d = ONE;
                            main_d  = in_data_i;
                        end
                    end
                    ONE: begin
                        // Simultaneous in/out replaces main directly; skid is only used when output stalls.
                        if (in_fire && out_fire) begin
                            main_d = in_data_i;
                        end else if (in_fire) begin
                            state_d = TWO;
                            skid_d  = in_data_i;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            state_d = ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
`else
    assign in_ready_o = ~out_valid_o | out_ready_i;
    assign occ_o      = {1'b0, out_valid_o};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (!fc_bk_i) begin
            if (fc_flush_i) begin
                state_d = EMPTY;
                main_d  = RST_VAL;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_d = ONE;
                            main_d  = in_data_i;
                        end
                    end
                    ONE: begin
                        if (in_fire) begin
                            main_d = in_data_i;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hs_reg.sv
// Directed self-checking bench for pipe_hs_reg (default DW=32, RST_VAL=0); follows PIPE_HS_SKID_EN.
module tb_pipe_hs_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_ready_i;
    logic        fc_bk_i;
    logic        fc_flush_i;
    logic [1:0]  occ_o;

    int n_vec;
    int n_err;

    pipe_hs_reg #(.DW(32), .RST_VAL(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .out_ready_i(out_ready_i),
        .fc_bk_i    (fc_bk_i),
        .fc_flush_i (fc_flush_i),
        .occ_o      (occ_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] o);
        chk({tag, ".valid"}, {31'b0, out_valid_o}, {31'b0, v});
        chk({tag, ".data"},  out_data_o, d);
        chk({tag, ".occ"},   {30'b0, occ_o}, {30'b0, o});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        in_data_i = 32'h0;
        out_ready_i = 1'b0;
        fc_bk_i = 1'b0;
        fc_flush_i = 1'b0;

        // reset state
        #12;
        chk_out("reset", 1'b0, 32'h0, 2'd0);
        chk("reset.ready", {31'b0, in_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // streaming 1..5, one cycle behind
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data_i = i;
            #1;
            chk("stream.ready", {31'b0, in_ready_o}, 32'd1);
            cyc();
            chk_out("stream", 1'b1, i, 2'd1);
        end
        in_valid_i = 1'b0;
        cyc();
        // drained: main keeps its last value
        chk_out("drain", 1'b0, 32'd5, 2'd0);

        // backpressure A, B, C
        in_valid_i = 1'b1;
        out_ready_i = 1'b0;
        in_data_i = 32'hA;
        cyc();
        chk_out("bp.A", 1'b1, 32'hA, 2'd1);
        in_data_i = 32'hB;
        #1;
`ifdef PIPE_HS_SKID_EN
        chk("bp.readyB", {31'b0, in_ready_o}, 32'd1);
        cyc();
        chk_out("bp.AB", 1'b1, 32'hA, 2'd2);
        in_data_i = 32'hC;
        #1;
        chk("bp.readyC", {31'b0, in_ready_o}, 32'd0);
        cyc();
        chk_out("bp.hold", 1'b1, 32'hA, 2'd2);
        out_ready_i = 1'b1;
        #1;
        chk("bp.readyRel", {31'b0, in_ready_o}, 32'd0);
        cyc();
        chk_out("bp.B", 1'b1, 32'hB, 2'd1);
        chk("bp.readyB2", {31'b0, in_ready_o}, 32'd1);
        cyc();
        chk_out("bp.C", 1'b1, 32'hC, 2'd1);
`else
        chk("bp.readyB", {31'b0, in_ready_o}, 32'd0);
        cyc();
        chk_out("bp.hold1", 1'b1, 32'hA, 2'd1);
        cyc();
        chk_out("bp.hold2", 1'b1, 32'hA, 2'd1);
        out_ready_i = 1'b1;
        #1;
        chk("bp.readyRel", {31'b0, in_ready_o}, 32'd1);
        cyc();
        chk_out("bp.B", 1'b1, 32'hB, 2'd1);
        in_data_i = 32'hC;
        cyc();
        chk_out("bp.C", 1'b1, 32'hC, 2'd1);
`endif
        in_valid_i = 1'b0;
        cyc();
        chk_out("bp.drain", 1'b0, 32'hC, 2'd0);

        // hold for 2 cycles
        in_valid_i = 1'b1;
        in_data_i = 32'h10;
        cyc();
        chk_out("hold.pre", 1'b1, 32'h10, 2'd1);
        fc_bk_i = 1'b1;
        in_data_i = 32'h11;
        cyc();
        chk_out("hold.1", 1'b1, 32'h10, 2'd1);
        cyc();
        chk_out("hold.2", 1'b1, 32'h10, 2'd1);
        fc_bk_i = 1'b0;
        cyc();
        chk_out("hold.rel11", 1'b1, 32'h11, 2'd1);
        in_data_i = 32'h12;
        cyc();
        chk_out("hold.rel12", 1'b1, 32'h12, 2'd1);
        in_valid_i = 1'b0;
        cyc();
        chk_out("hold.drain", 1'b0, 32'h12, 2'd0);

        // flush at full occupancy, coincident with an output handshake
        in_valid_i = 1'b1;
        out_ready_i = 1'b0;
        in_data_i = 32'h20;
        cyc();
`ifdef PIPE_HS_SKID_EN
        in_data_i = 32'h21;
        cyc();
        chk_out("flush.full", 1'b1, 32'h20, 2'd2);
`else
        chk_out("flush.full", 1'b1, 32'h20, 2'd1);
`endif
        fc_flush_i = 1'b1;
        out_ready_i = 1'b1;
        in_data_i = 32'hDEAD;
        cyc();
        chk_out("flush", 1'b0, 32'h0, 2'd0);
        fc_flush_i = 1'b0;
        in_valid_i = 1'b0;
        cyc();
        chk_out("flush.after", 1'b0, 32'h0, 2'd0);

        // hold beats flush
        in_valid_i = 1'b1;
        out_ready_i = 1'b0;
        in_data_i = 32'h30;
        cyc();
        chk_out("prio.pre", 1'b1, 32'h30, 2'd1);
        fc_bk_i = 1'b1;
        fc_flush_i = 1'b1;
        out_ready_i = 1'b1;
        in_data_i = 32'h31;
        cyc();
        chk_out("prio.bkflush", 1'b1, 32'h30, 2'd1);
        fc_bk_i = 1'b0;
        fc_flush_i = 1'b0;
        in_data_i = 32'h32;
        cyc();
        chk_out("prio.rel", 1'b1, 32'h32, 2'd1);

        // asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("areset", 1'b0, 32'h0, 2'd0);
        chk("areset.ready", {31'b0, in_ready_o}, 32'd1);
        cyc();
        chk_out("areset.held", 1'b0, 32'h0, 2'd0);
        rst_n = 1'b1;
        in_valid_i = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
